m_stage_pipe_reg: RTL and testbench
===================================

// Module: m_stage_pipe_reg
// PURPOSE
//  Parametrised E->M pipeline register for the five-stage MIPS core. It carries Instr, PC, ALUOut, WriteData and WriteReg.
//  Adds valid/ready handshakes on both sides, a synchronous flush that inserts a bubble, and an optional 1-entry skid
//  buffer, so the stage can stall without a combinational ready path from M back to E.
//  Sits between the E-stage outputs and the M-stage/DM inputs.
// PARAMETERS
//  DATA_W  32  width of ALUOut/WriteData payload
//  PC_W    32  width of PC payload
//  REG_W   5   width of WriteReg payload
//  SKID    1   1: skid entry present, in_ready registered; 0: single entry, in_ready = ~out_valid | out_ready
//  PC_RST  0   value driven on PC_M when the stage is empty (reset/flush/drained)
// PORTS
//  clk         in   1       clock, rising edge
//  reset       in   1       asynchronous, active-high; clears all state
//  flush       in   1       sync bubble insert: drop held and incoming entries
//  in_valid    in   1       E stage presents a valid instruction
//  in_ready    out  1       stage accepts this cycle (xfer_in = in_valid & in_ready)
//  Instr_E     in   32      instruction word
//  PC_E        in   PC_W    instruction PC
//  ALUOutE     in   DATA_W  ALU result
//  WriteDataE  in   DATA_W  store data
//  WriteRegE   in   REG_W   destination register
//  out_valid   out  1       M stage payload valid
//  out_ready   in   1       M stage consumes (xfer_out = out_valid & out_ready)
//  Instr_M, PC_M, ALUOutM, WriteDataM, WriteRegM  out  widths as inputs  head-entry payload
//  occupancy   out  2       entries held: 0, 1 or 2 (2 only when SKID=1)
// BEHAVIOUR
//  Reset (async, immediate): state EMPTY; out_valid=0; occupancy=0; in_ready=1; Instr_M/ALUOutM/WriteDataM/WriteRegM=0; PC_M=PC_RST.
//  Storage: main entry (drives outputs) plus, if SKID=1, skid entry.
//  Whenever main is invalid, its payload regs are zero and PC=PC_RST. Instr_M=0 is a nop, so downstream needs no valid gating.
//  States and transitions (evaluated at posedge, flush=0):
//   EMPTY: xfer_in -> FULL, main<=E inputs. Else hold.
//   FULL:  xfer_in&xfer_out -> FULL, main<=E inputs. xfer_out only -> EMPTY, main cleared.
//          xfer_in only -> SKID, skid<=E inputs (SKID=1). Neither -> hold.
//   SKID:  in_ready=0. xfer_out -> FULL, main<=skid, skid cleared. Else hold.
//  in_ready: SKID=1: ~skid_valid (registered, no comb path from out_ready). SKID=0: ~out_valid | out_ready.
//  With SKID=0, the SKID state never occurs; FULL + xfer_in without xfer_out is impossible.
//  Latency: an accepted entry appears on the M outputs the cycle after xfer_in.
//  Order is strict FIFO; no entry is lost or duplicated.
//  flush=1 at posedge: next state EMPTY; main and skid cleared.
//   Flush wins over a simultaneous xfer_in, which is dropped (E must treat it as killed).
//   A simultaneous xfer_out still counts as delivered.
//  Reset asserted mid-operation: all entries discarded at once, whatever the handshake state.
//  Payload is stored without modification; widths are fixed by the parameters; no arithmetic.
//  occupancy = main_valid + skid_valid; out_valid = main_valid.
// TESTING
//  1 Reset: assert reset mid-cycle with 2 entries held -> outputs 0 at once, PC_M=PC_RST, occupancy=0, in_ready=1.
//  2 Streaming (SKID=1): out_ready=1, Instr_E=0x8C010004..+4 every cycle -> Instr_M matches 1 cycle later; occupancy stays 1.
//  3 Stall (SKID=1): hold out_ready=0 while sending A,B,C -> A in main, B in skid, in_ready=0, C held by E.
//     Release out_ready -> M outputs A,B,C in order, one per cycle.
//  4 Flush: 2 entries held, flush=1 with in_valid=1 (D) -> next cycle out_valid=0, Instr_M=0, occupancy=0, D never appears.
//  5 Flush with out_ready=1 in the same cycle: the head entry counts as consumed; the next cycle is a bubble.
//  6 SKID=0: out_ready=0 with main full -> in_ready=0 the same cycle.
//     Raise out_ready -> in_ready=1 combinationally; back-to-back transfer has no bubble.

Source files
------------

// File: rtl/m_stage_pipe_reg.sv
// E->M pipeline register for the five-stage MIPS core: valid/ready on both sides,
// synchronous flush, optional one-entry skid buffer so in_ready can be registered.
module m_stage_pipe_reg #(
    parameter int unsigned     DATA_W = 32,
    parameter int unsigned     PC_W   = 32,
    parameter int unsigned     REG_W  = 5,
    parameter int unsigned     SKID   = 1,
    parameter logic [PC_W-1:0] PC_RST = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       Instr_E,
    input  logic [PC_W-1:0]   PC_E,
    input  logic [DATA_W-1:0] ALUOutE,
    input  logic [DATA_W-1:0] WriteDataE,
    input  logic [REG_W-1:0]  WriteRegE,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       Instr_M,
    output logic [PC_W-1:0]   PC_M,
    output logic [DATA_W-1:0] ALUOutM,
    output logic [DATA_W-1:0] WriteDataM,
    output logic [REG_W-1:0]  WriteRegM,
    output logic [1:0]        occupancy
);

    localparam int unsigned PW = 32 + PC_W + 2 * DATA_W + REG_W;
    // An empty entry reads as a nop at PC_RST, so M needs no valid gating.
    localparam logic [PW-1:0] BUBBLE = {32'd0, PC_RST, {(2 * DATA_W + REG_W){1'b0}}};

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_FULL,
        ST_SKID
    } state_t;

    state_t        state, stateNext;
    logic [PW-1:0] mainQ, mainD, skidQ, skidD, inPayload;
    logic          mainValid, skidValid, xferIn, xferOut;

    assign inPayload = {Instr_E, PC_E, ALUOutE, WriteDataE, WriteRegE};
    assign mainValid = (state != ST_EMPTY);
    assign skidValid = (state == ST_SKID);
    assign xferIn    = in_valid & in_ready;
    assign xferOut   = mainValid & out_ready;

    generate
        if (SKID != 0) begin : gReadyReg
            assign in_ready = ~skidValid;
        end else begin : gReadyComb
            assign in_ready = ~mainValid | out_ready;
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_EMPTY;
            mainQ <= BUBBLE;
            skidQ <= BUBBLE;
        end else begin
            state <= stateNext;
            mainQ <= mainD;
            skidQ <= skidD;
        end
    end

    always_comb begin
        stateNext = state;
        mainD     = mainQ;
        skidD     = skidQ;
        if (flush) begin
            stateNext = ST_EMPTY;
            mainD     = BUBBLE;
            skidD     = BUBBLE;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (xferIn) begin
                        stateNext = ST_FULL;
                        mainD     = inPayload;
                    end
                end
                ST_FULL: begin
                    if (xferIn && xferOut) begin
                        mainD = inPayload;
                    end else if (xferOut) begin
                        stateNext = ST_EMPTY;
                        mainD     = BUBBLE;
                    end else if (xferIn && (SKID != 0)) begin
                        stateNext = ST_SKID;
                        skidD     = inPayload;
                    end
                end
                ST_SKID: begin
                    if (xferOut) begin
                        stateNext = ST_FULL;
                        mainD     = skidQ;
                        skidD     = BUBBLE;
                    end
                end
                default: begin
                    stateNext = ST_EMPTY;
                    mainD     = BUBBLE;
                    skidD     = BUBBLE;
                end
            endcase
        end
    end

    assign {Instr_M, PC_M, ALUOutM, WriteDataM, WriteRegM} = mainQ;
    assign out_valid = mainValid;
    assign occupancy = {1'b0, mainValid} + {1'b0, skidValid};

endmodule

// File: tb/tb_m_stage_pipe_reg.sv
// Scoreboard bench for m_stage_pipe_reg: one instance with the skid entry, one without.
module tb_m_stage_pipe_reg;

    localparam logic [31:0] PCR = 32'hBFC0_0000;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] alu;
        logic [31:0] wd;
        logic [4:0]  wr;
    } pay_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // skid instance
    logic        flush1 = 1'b0, inValid1 = 1'b0, outReady1 = 1'b0;
    logic        inReady1, outValid1;
    pay_t        in1;
    logic [31:0] instrM1, pcM1, aluM1, wdM1;
    logic [4:0]  wrM1;
    logic [1:0]  occ1;

    // single-entry instance
    logic        flush0 = 1'b0, inValid0 = 1'b0, outReady0 = 1'b0;
    logic        inReady0, outValid0;
    pay_t        in0;
    logic [31:0] instrM0, pcM0, aluM0, wdM0;
    logic [4:0]  wrM0;
    logic [1:0]  occ0;

    int          checks = 0;
    int          errors = 0;
    int unsigned k1 = 0;
    int unsigned k0 = 1000;
    pay_t        q1[$];
    pay_t        q0[$];

    m_stage_pipe_reg #(.DATA_W(32), .PC_W(32), .REG_W(5), .SKID(1), .PC_RST(PCR)) dut (
        .clk(clk), .reset(reset), .flush(flush1),
        .in_valid(inValid1), .in_ready(inReady1),
        .Instr_E(in1.instr), .PC_E(in1.pc), .ALUOutE(in1.alu),
        .WriteDataE(in1.wd), .WriteRegE(in1.wr),
        .out_valid(outValid1), .out_ready(outReady1),
        .Instr_M(instrM1), .PC_M(pcM1), .ALUOutM(aluM1),
        .WriteDataM(wdM1), .WriteRegM(wrM1), .occupancy(occ1)
    );

    m_stage_pipe_reg #(.DATA_W(32), .PC_W(32), .REG_W(5), .SKID(0), .PC_RST(32'd0)) dut0 (
        .clk(clk), .reset(reset), .flush(flush0),
        .in_valid(inValid0), .in_ready(inReady0),
        .Instr_E(in0.instr), .PC_E(in0.pc), .ALUOutE(in0.alu),
        .WriteDataE(in0.wd), .WriteRegE(in0.wr),
        .out_valid(outValid0), .out_ready(outReady0),
        .Instr_M(instrM0), .PC_M(pcM0), .ALUOutM(aluM0),
        .WriteDataM(wdM0), .WriteRegM(wrM0), .occupancy(occ0)
    );

    function automatic pay_t mk(input int unsigned k);
        pay_t p;
        p.instr = 32'h8C01_0004 + 32'(4 * k);
        p.pc    = 32'h0040_0000 + 32'(4 * k);
        p.alu   = 32'(k * 7 + 3);
        p.wd    = ~32'(k);
        p.wr    = k[4:0];
        return p;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Compare both instances' outputs against the heads of their scoreboards.
    task automatic checkNow();
        pay_t e1, e0;
        e1 = '0;
        e1.pc = PCR;
        if (q1.size() != 0) e1 = q1[0];
        e0 = '0;
        if (q0.size() != 0) e0 = q0[0];
        chk("out_valid1", 32'(outValid1), 32'(q1.size() != 0));
        chk("occupancy1", 32'(occ1), 32'(q1.size()));
        chk("in_ready1",  32'(inReady1), 32'(q1.size() < 2));
        chk("Instr_M1",   instrM1, e1.instr);
        chk("PC_M1",      pcM1, e1.pc);
        chk("ALUOutM1",   aluM1, e1.alu);
        chk("WriteDataM1", wdM1, e1.wd);
        chk("WriteRegM1", 32'(wrM1), 32'(e1.wr));
        chk("out_valid0", 32'(outValid0), 32'(q0.size() != 0));
        chk("occupancy0", 32'(occ0), 32'(q0.size()));
        chk("in_ready0",  32'(inReady0), 32'((q0.size() == 0) || outReady0));
        chk("Instr_M0",   instrM0, e0.instr);
        chk("PC_M0",      pcM0, e0.pc);
        chk("ALUOutM0",   aluM0, e0.alu);
    endtask

    // Called just after a falling edge with inputs set; returns at the next falling edge.
    task automatic cycle();
        bit acc1, del1, acc0, del0;
        #1;
        checkNow();
        acc1 = inValid1 && inReady1 && !reset;
        del1 = outValid1 && outReady1 && !reset;
        acc0 = inValid0 && inReady0 && !reset;
        del0 = outValid0 && outReady0 && !reset;
        if (del1) void'(q1.pop_front());
        if (flush1) q1.delete();
        else if (acc1) q1.push_back(in1);
        if (acc1) k1++;
        if (del0) void'(q0.pop_front());
        if (acc0) begin
            q0.push_back(in0);
            k0++;
        end
        @(posedge clk);
        @(negedge clk);
        in1 = mk(k1);
        in0 = mk(k0);
    endtask

    initial begin
        in1 = mk(k1);
        in0 = mk(k0);
        @(negedge clk);
        repeat (2) cycle();
        reset = 1'b0;
        cycle();

        // streaming through the skid instance
        outReady1 = 1'b1;
        inValid1  = 1'b1;
        repeat (8) cycle();
        inValid1 = 1'b0;
        repeat (2) cycle();

        // stall: A in main, B in skid, C held by E, then drain in order
        outReady1 = 1'b0;
        inValid1  = 1'b1;
        repeat (4) cycle();
        outReady1 = 1'b1;
        repeat (2) cycle();
        inValid1 = 1'b0;
        repeat (3) cycle();

        // flush with two held and D offered
        outReady1 = 1'b0;
        inValid1  = 1'b1;
        repeat (2) cycle();
        flush1 = 1'b1;
        cycle();
        flush1   = 1'b0;
        inValid1 = 1'b0;
        cycle();
        // flush kills an accepted incoming entry
        inValid1 = 1'b1;
        cycle();
        flush1 = 1'b1;
        cycle();
        flush1   = 1'b0;
        inValid1 = 1'b0;
        repeat (2) cycle();

        // flush together with a consuming M stage
        inValid1 = 1'b1;
        repeat (2) cycle();
        inValid1  = 1'b0;
        outReady1 = 1'b1;
        flush1    = 1'b1;
        cycle();
        flush1 = 1'b0;
        repeat (2) cycle();

        // single-entry instance: combinational ready, back-to-back streaming
        inValid0  = 1'b1;
        outReady0 = 1'b0;
        repeat (3) cycle();
        outReady0 = 1'b1;
        repeat (6) cycle();
        inValid0 = 1'b0;
        repeat (2) cycle();

        // asynchronous reset while entries are held
        outReady1 = 1'b0;
        outReady0 = 1'b0;
        inValid1  = 1'b1;
        inValid0  = 1'b1;
        repeat (2) cycle();
        inValid1 = 1'b0;
        inValid0 = 1'b0;
        #1;
        checkNow();
        #1;
        reset = 1'b1;
        #1;
        q1.delete();
        q0.delete();
        checkNow();
        @(negedge clk);
        reset = 1'b0;
        repeat (2) cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
